// File: rtl/cbd_byte_feeder.sv
// cbd_byte_feeder: buffers SHAKE256 squeeze blocks and slices them into a
// 64-bit byte stream for the CBD sampler (16 words for eta=2, 24 for eta=3).
module cbd_byte_feeder #(
    parameter int RATE_WORDS = 17,
    parameter int WORD_W     = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [1:0]                     i_eta,
    input  logic [RATE_WORDS*WORD_W-1:0]   i_block,
    input  logic                           i_block_valid,
    output logic                           o_block_ready,
    output logic [WORD_W-1:0]              o_ibytes,
    output logic                           o_ibytes_valid,
    input  logic                           i_ibytes_ready,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int         BLK_W    = RATE_WORDS * WORD_W;
    localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLK,
        SEND,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [BLK_W-1:0]   r_buffer;
    logic [4:0]         r_wordIdx;
    logic [4:0]         r_sent;
    logic [4:0]         r_target;

    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic               w_refill;
    logic               w_load;

    // The outgoing word is always the top slice of the buffer, so the data
    // output is a pure register with no path from any input.
    assign o_ibytes = r_buffer[BLK_W-1 -: WORD_W];

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state, handshake decode and status outputs.
    always_comb begin
        w_nextState    = r_state;
        w_accept       = 1'b0;
        w_xfer         = 1'b0;
        w_last         = 1'b0;
        w_refill       = 1'b0;
        o_block_ready  = 1'b0;
        o_ibytes_valid = 1'b0;
        o_busy         = (r_state != IDLE);
        o_done         = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = i_start && ((i_eta == 2'd2) || (i_eta == 2'd3));
                if (w_accept) begin
                    w_nextState = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                o_block_ready = 1'b1;
                if (i_block_valid) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                o_ibytes_valid = 1'b1;
                w_xfer         = i_ibytes_ready;
                w_last         = w_xfer && (r_sent == r_target - 5'd1);
                w_refill       = w_xfer && (r_wordIdx == LAST_IDX) &&
                                 (r_sent < r_target - 5'd1);
                o_block_ready  = w_refill;
                if (w_last) begin
                    w_nextState = DONE;
                end else if (w_refill && !i_block_valid) begin
                    w_nextState = WAIT_BLK;
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_load = o_block_ready && i_block_valid;
    end

    // Datapath: latch the word target on start, load or shift the block
    // buffer, and count words per block and per polynomial.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buffer  <= '0;
            r_wordIdx <= 5'd0;
            r_sent    <= 5'd0;
            r_target  <= 5'd0;
        end else begin
            if (w_accept) begin
                r_target <= (i_eta == 2'd3) ? 5'd24 : 5'd16;
                r_sent   <= 5'd0;
            end else if (w_xfer) begin
                r_sent <= r_sent + 5'd1;
            end
            if (w_load) begin
                r_buffer  <= i_block;
                r_wordIdx <= 5'd0;
            end else if (w_xfer) begin
                r_buffer  <= {r_buffer[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                r_wordIdx <= r_wordIdx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_cbd_byte_feeder.sv
// tb_cbd_byte_feeder: self-checking bench for cbd_byte_feeder using a
// byte-stream reference model and a table of stream scenarios.
module tb_cbd_byte_feeder;

    localparam int BLK_W = 1088;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       eta;
    logic [BLK_W-1:0] block;
    logic             blockValid;
    logic             blockReady;
    logic [63:0]      ibytes;
    logic             ibValid;
    logic             ibReady;
    logic             busy;
    logic             done;

    int               checkCount = 0;
    int               passCount  = 0;
    logic [63:0]      capWords [0:31];

    typedef struct {
        logic [1:0] eta;
        int         b0Start;
        int         b1Start;
        int         b1Delay;
        int         readyPct;
        int         restartAt;
        int         expWords;
        int         expBlocks;
    } vec_t;

    vec_t vecs [0:7];

    // Free-running clock.
    always #5 clk = ~clk;

    cbd_byte_feeder dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_eta          (eta),
        .i_block        (block),
        .i_block_valid  (blockValid),
        .o_block_ready  (blockReady),
        .o_ibytes       (ibytes),
        .o_ibytes_valid (ibValid),
        .i_ibytes_ready (ibReady),
        .o_busy         (busy),
        .o_done         (done)
    );

    function automatic logic [BLK_W-1:0] makeBlock(input int first);
        logic [BLK_W-1:0] b;
        b = '0;
        for (int i = 0; i < 136; i++) begin
            b[BLK_W-1-8*i -: 8] = 8'((first + i) % 256);
        end
        return b;
    endfunction

    // Reference: the stream is block0's 136 bytes followed by block1's bytes;
    // word k is stream bytes 8k..8k+7, first byte most significant.
    function automatic logic [63:0] refWord(input int b0, input int b1, input int k);
        logic [63:0] w;
        int          idx;
        int          v;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            idx = 8 * k + j;
            v   = (idx < 136) ? (b0 + idx) % 256 : (b1 + idx - 136) % 256;
            w[63-8*j -: 8] = 8'(v);
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   xfers;
        int   handshakes;
        int   gaps;
        int   doneCount;
        int   lastXfer;
        int   doneCycle;
        int   firstValid;
        int   lateCount;
        int   stage;
        logic holding;
        logic [63:0] heldWord;
        xfers = 0; handshakes = 0; gaps = 0; doneCount = 0;
        lastXfer = -1; doneCycle = -1; firstValid = -1;
        lateCount = 0; stage = 0; holding = 1'b0; heldWord = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start = (c == 0) || ((v.restartAt > 0) && (c == v.restartAt));
            if (c == 0) begin
                eta = v.eta;
            end else if ((v.restartAt > 0) && (c == v.restartAt)) begin
                eta = (v.eta == 2'd2) ? 2'd3 : 2'd2;
            end
            ibReady = ($urandom_range(99) < v.readyPct);
            if (stage == 0) begin
                block      = makeBlock(v.b0Start);
                blockValid = 1'b1;
            end else begin
                block      = makeBlock(v.b1Start);
                blockValid = (lateCount >= v.b1Delay);
            end
            #1;
            if (holding) begin
                checkOutput("stall valid held", 64'(ibValid), 64'd1);
                checkOutput("stall data held", ibytes, heldWord);
                holding = 1'b0;
            end
            if (ibValid && (firstValid < 0)) firstValid = c;
            if (busy && !ibValid && !done && (xfers > 0)) gaps++;
            if (blockReady && blockValid) begin
                handshakes++;
                stage = 1;
            end else if ((stage == 1) && blockReady) begin
                lateCount++;
            end
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = c;
            end
            if (ibValid && ibReady) begin
                if (xfers < 32) capWords[xfers] = ibytes;
                checkOutput($sformatf("word %0d", xfers), ibytes,
                            refWord(v.b0Start, v.b1Start, xfers));
                xfers++;
                lastXfer = c;
            end else if (ibValid) begin
                holding  = 1'b1;
                heldWord = ibytes;
            end
            if ((doneCycle >= 0) && (c == doneCycle + 1)) begin
                checkOutput("idle after done", 64'(busy), 64'd0);
            end
            if ((doneCycle >= 0) && (c >= doneCycle + 3)) break;
        end
        start = 1'b0;
        checkOutput("done pulses", 64'(doneCount), 64'd1);
        checkOutput("word count", 64'(xfers), 64'(v.expWords));
        checkOutput("block handshakes", 64'(handshakes), 64'(v.expBlocks));
        checkOutput("valid gap cycles", 64'(gaps), 64'((v.eta == 2'd3) ? v.b1Delay : 0));
        checkOutput("start to first valid", 64'(firstValid), 64'd2);
        checkOutput("done after last word", 64'(doneCycle - lastXfer), 64'd1);
    endtask

    initial begin
        int   xfers;
        logic sawBusy;
        logic sawReady;

        rst = 1'b1; start = 1'b0; eta = 2'd0; block = '0;
        blockValid = 1'b0; ibReady = 1'b0;

        // Fixed scenarios from the stream rules, then randomized ones.
        vecs[0] = '{2'd2, 0, 0,     0, 100, 0, 16, 1};
        vecs[1] = '{2'd3, 0, 8'h88, 0, 100, 0, 24, 2};
        vecs[2] = '{2'd3, 0, 8'h88, 5, 100, 0, 24, 2};
        vecs[3] = '{2'd2, 0, 0,     0, 50,  0, 16, 1};
        vecs[4] = '{2'd2, 7, 0,     0, 100, 6, 16, 1};
        for (int i = 5; i < 8; i++) begin
            vecs[i].eta       = (i == 5) ? 2'd3 : 2'($urandom_range(3, 2));
            vecs[i].b0Start   = $urandom_range(255);
            vecs[i].b1Start   = $urandom_range(255);
            vecs[i].b1Delay   = $urandom_range(4);
            vecs[i].readyPct  = 50;
            vecs[i].restartAt = 0;
            vecs[i].expWords  = (vecs[i].eta == 2'd3) ? 24 : 16;
            vecs[i].expBlocks = (vecs[i].eta == 2'd3) ? 2 : 1;
        end

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset ibytes", ibytes, 64'd0);
        checkOutput("reset valid", 64'(ibValid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset block ready", 64'(blockReady), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            if (i == 0) begin
                checkOutput("eta2 word0", capWords[0], 64'h0001020304050607);
                checkOutput("eta2 word15", capWords[15], 64'h78797A7B7C7D7E7F);
            end
            if (i == 1) begin
                checkOutput("eta3 word16", capWords[16], 64'h8081828384858687);
                checkOutput("eta3 word17", capWords[17], 64'h88898A8B8C8D8E8F);
            end
            if (i == 2) begin
                checkOutput("late block word17", capWords[17], 64'h88898A8B8C8D8E8F);
            end
        end

        // Starts with an unsupported eta must leave the feeder idle.
        sawBusy = 1'b0; sawReady = 1'b0;
        block = makeBlock(0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start      = (c < 2);
            eta        = (c == 0) ? 2'd0 : 2'd1;
            blockValid = 1'b1;
            ibReady    = 1'b1;
            #1;
            sawBusy  = sawBusy | busy;
            sawReady = sawReady | blockReady;
        end
        checkOutput("bad eta busy", 64'(sawBusy), 64'd0);
        checkOutput("bad eta block ready", 64'(sawReady), 64'd0);

        // Reset in the middle of a stream.
        @(negedge clk);
        start = 1'b1; eta = 2'd2; block = makeBlock(0); blockValid = 1'b1; ibReady = 1'b1;
        xfers = 0;
        for (int c = 0; (c < 40) && (xfers < 5); c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (ibValid && ibReady) xfers++;
        end
        checkOutput("transfers before reset", 64'(xfers), 64'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset ibytes", ibytes, 64'd0);
        checkOutput("midreset valid", 64'(ibValid), 64'd0);
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset block ready", 64'(blockReady), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[0]);
        checkOutput("after reset word0", capWords[0], 64'h0001020304050607);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
